maxterm_extractor: RTL and testbench
====================================

# maxterm_extractor

Sequential decoder for the truth-table/PoS flow: drives every input combination of an external N-input combinational function under test, captures its output into a truth table, and then emits the function's maxterm indices in ascending order over a valid/ready stream. It is the inverse of the maxterm-list → product-of-sums evaluators. It sits between a PoS/SoP function block (driven through `sel`, read back through `f_in`) and any consumer of the maxterm list (checker, display, logger).

## Interface
- `N`, default 4: number of function inputs; legal range 2..4. `sel` order is {X,Y,W,Z} for N=4 and {X,Y,Z} for N=3, MSB first.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  begin extraction; sampled only in IDLE.
- `f_in`  in  1  output of function under test for the current `sel`.
- `sel`  out  N  input combination applied to the function under test.
- `term`  out  N  current maxterm index.
- `term_valid`  out  1  `term` is valid; held until accepted.
- `term_ready`  in  1  consumer accepts `term` when high with `term_valid`.
- `count`  out  N+1  number of maxterms (zeros) found during the sweep.
- `table`  out  2^N  captured truth table; bit i = f(i).
- `busy`  out  1  high from the cycle after `start` until FIN.
- `done`  out  1  one-cycle pulse at end of extraction.

## Operation
- States: IDLE, DRIVE, SAMPLE, SCAN, EMIT, FIN. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE: `busy`=0. On `start`=1: clear `table` and `count`, set `sel`=0, go to DRIVE.
- DRIVE: `sel` holds k. This is a one-cycle settle for the function under test. Go to SAMPLE.
- SAMPLE: `table[k]` <= `f_in`; if `f_in`=0, `count` <= `count`+1.
  - If k = 2^N−1, set idx=0 and go to SCAN.
  - Otherwise `sel` <= k+1 and go to DRIVE.
- SCAN, one index per cycle:
  - If `table[idx]`=1: if idx is last, go to FIN; otherwise idx+1 and stay in SCAN.
  - If `table[idx]`=0: `term` <= idx, `term_valid` <= 1, go to EMIT.
- EMIT: hold `term` and `term_valid`=1 until `term_ready`=1. On that handshake cycle, `term_valid` <= 0 at the next edge.
  - If idx is last, go to FIN; otherwise idx+1 and go to SCAN.
- FIN: `done`=1 and `busy`=0 for exactly one cycle, then IDLE.
- `table` and `count` hold their final values in IDLE until the next `start` or `rst`. `sel` holds its last value in IDLE.
- Widths: idx and `sel` are N bits; the last index is detected by compare, never by wrap-around. `count` is N+1 bits so that 2^N zeros (all-zero function) does not overflow.
- `start` outside IDLE is ignored.
- `term_ready` outside EMIT is ignored.
- `rst` in any state, including mid-sweep or mid-handshake: next state is IDLE and every output returns to its reset value. A pending term is dropped.
- `f_in` must be 0/1 in SAMPLE. An X there is a bench error; no recovery is defined.

## Timing
- Reset values: `sel`=0, `term`=0, `term_valid`=0, `count`=0, `table`=0, `busy`=0, `done`=0; state IDLE.
- `start` at edge t0 → DRIVE with `sel`=0 and `busy`=1 from t0+1.
- Sweep takes 2·2^N cycles: 32 for N=4, 16 for N=3.
- Scan costs one cycle per 1-entry. Each 0-entry costs one SCAN cycle plus at least one EMIT cycle; each cycle `term_ready` is low in EMIT adds one cycle.
- With `term_ready` tied high, total from the first DRIVE cycle to the FIN cycle inclusive is 2·2^N + 2^N + Z + 1 cycles, where Z is the maxterm count.
- Back-to-back: `start` high in the cycle after FIN (IDLE) begins a new run immediately.

## Test plan
- N=3, function with maxterms 1,2,6,7 (f=1 at 0,3,4,5), `term_ready`=1 → terms 1,2,6,7 in order; `count`=4; `table`=8'h39; one `done` pulse; 29 cycles from the first DRIVE cycle to FIN inclusive.
- N=4, maxterms 1,2,4,7,8,9,15, `term_ready` toggling 0/1 each cycle → same seven terms in order, each `term` stable while `term_valid` is high and `term_ready` is low; `count`=7; `table`=16'h7C69.
- N=4, f≡1 → no `term_valid` ever; `count`=0; `table`=16'hFFFF; `done` pulses after 32 sweep + 16 scan cycles.
- N=4, f≡0 → terms 0..15; `count`=5'd16, with no overflow.
- `rst` asserted during SAMPLE of k=5, then during EMIT with `term_valid`=1 → next cycle all outputs at reset values and state IDLE; a fresh `start` runs a full correct extraction.
- `start` pulsed while `busy`=1 → ignored, the run completes normally; `start` in the cycle after FIN → a second run with identical results.

Source files
------------

// File: rtl/maxterm_extractor_if.sv
// Maxterm output stream: index plus valid/ready handshake.
// The extractor drives the master side; the consumer of the maxterm list takes the slave side.
interface maxterm_extractor_if #(
    parameter int unsigned N = 4
);
    logic [N-1:0] term;
    logic         term_valid;
    logic         term_ready;

    modport master (
        output term,
        output term_valid,
        input  term_ready
    );

    modport slave (
        input  term,
        input  term_valid,
        output term_ready
    );
endinterface

// File: rtl/maxterm_extractor.sv
// Sweeps every input combination of an external N-input function, captures its truth table,
// then streams the maxterm indices (zeros of the function) in ascending order.
module maxterm_extractor #(
    parameter int unsigned N = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                f_in,
    output logic [N-1:0]        sel,
    output logic [N:0]          count,
    output logic [2**N-1:0]     truth_table,
    output logic                busy,
    output logic                done,
    maxterm_extractor_if.master term_if
);

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StSample,
        StScan,
        StEmit,
        StFin
    } state_e;

    localparam logic [N-1:0] LastIdx = '1;

    state_e       state;
    logic [N-1:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= StIdle;
            sel                <= '0;
            idx                <= '0;
            count              <= '0;
            truth_table        <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            term_if.term       <= '0;
            term_if.term_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        truth_table <= '0;
                        count       <= '0;
                        sel         <= '0;
                        busy        <= 1'b1;
                        state       <= StDrive;
                    end
                end
                // One cycle for the function under test to settle on the new sel.
                StDrive: state <= StSample;
                StSample: begin
                    truth_table[sel] <= f_in;
                    if (!f_in) begin
                        count <= count + (N+1)'(1);
                    end
                    if (sel == LastIdx) begin
                        idx   <= '0;
                        state <= StScan;
                    end else begin
                        sel   <= sel + N'(1);
                        state <= StDrive;
                    end
                end
                StScan: begin
                    if (truth_table[idx]) begin
                        if (idx == LastIdx) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= StFin;
                        end else begin
                            idx <= idx + N'(1);
                        end
                    end else begin
                        term_if.term       <= idx;
                        term_if.term_valid <= 1'b1;
                        state              <= StEmit;
                    end
                end
                StEmit: begin
                    if (term_if.term_ready) begin
                        term_if.term_valid <= 1'b0;
                        if (idx == LastIdx) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= StFin;
                        end else begin
                            idx   <= idx + N'(1);
                            state <= StScan;
                        end
                    end
                end
                StFin: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_maxterm_extractor.sv
// Drives an N=3 and an N=4 extractor against bench-side truth tables and checks the emitted
// maxterm stream, count, table, handshake hold behaviour, cycle totals and reset recovery.
module tb_maxterm_extractor;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic ready;
    bit   use3;

    logic [7:0]  tt3;
    logic [15:0] tt4;

    logic [2:0] sel3;
    logic [3:0] sel4;
    logic [3:0] count3;
    logic [4:0] count4;
    logic [7:0] table3;
    logic [15:0] table4;
    logic busy3, busy4, done3, done4;
    logic f3, f4;

    maxterm_extractor_if #(.N(3)) if3 ();
    maxterm_extractor_if #(.N(4)) if4 ();

    assign f3 = tt3[sel3];
    assign f4 = tt4[sel4];
    assign if3.term_ready = ready;
    assign if4.term_ready = ready;

    maxterm_extractor #(.N(3)) dut3 (
        .clk         (clk),
        .rst         (rst),
        .start       (start & use3),
        .f_in        (f3),
        .sel         (sel3),
        .count       (count3),
        .truth_table (table3),
        .busy        (busy3),
        .done        (done3),
        .term_if     (if3)
    );

    maxterm_extractor #(.N(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .start       (start & ~use3),
        .f_in        (f4),
        .sel         (sel4),
        .count       (count4),
        .truth_table (table4),
        .busy        (busy4),
        .done        (done4),
        .term_if     (if4)
    );

    // View of whichever DUT is currently under test.
    logic [3:0]  m_sel, m_term;
    logic [4:0]  m_count;
    logic [15:0] m_table;
    logic        m_valid, m_busy, m_done;
    assign m_sel   = use3 ? {1'b0, sel3} : sel4;
    assign m_term  = use3 ? {1'b0, if3.term} : if4.term;
    assign m_valid = use3 ? if3.term_valid : if4.term_valid;
    assign m_count = use3 ? {1'b0, count3} : count4;
    assign m_table = use3 ? {8'h00, table3} : table4;
    assign m_busy  = use3 ? busy3 : busy4;
    assign m_done  = use3 ? done3 : done4;

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rst_sel"},   32'(m_sel),   32'd0);
        chk({tag, "_rst_term"},  32'(m_term),  32'd0);
        chk({tag, "_rst_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_rst_count"}, 32'(m_count), 32'd0);
        chk({tag, "_rst_table"}, 32'(m_table), 32'd0);
        chk({tag, "_rst_busy"},  32'(m_busy),  32'd0);
        chk({tag, "_rst_done"},  32'(m_done),  32'd0);
    endtask

    // Called at a negedge with the selected DUT in IDLE; returns at a negedge in IDLE.
    // rmode: 0 ready tied high, 1 toggling, 2 random. abort: 0 none, 1 in SAMPLE k=5,
    // 2 at the first pending term. poke: pulse start mid-run.
    task automatic run(input bit n3, input logic [15:0] f, input int rmode, input int abort,
                       input bit poke, input string tag);
        int          size;
        int          cyc;
        logic [3:0]  exp_q[$];
        logic [3:0]  got_q[$];
        logic [15:0] exp_tab;
        logic [3:0]  held;
        bit          held_pend;

        use3 = n3;
        size = n3 ? 8 : 16;
        if (n3) tt3 = f[7:0];
        else tt4 = f;
        exp_tab = n3 ? {8'h00, f[7:0]} : f;
        for (int i = 0; i < size; i++) begin
            if (!f[i]) exp_q.push_back(4'(i));
        end

        start = 1'b1;
        ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        chk({tag, "_busy_first"}, 32'(m_busy), 32'd1);
        chk({tag, "_sel_first"},  32'(m_sel),  32'd0);

        held_pend = 1'b0;
        held      = '0;
        while (1) begin
            case (rmode)
                0:       ready = 1'b1;
                1:       ready = cyc[0];
                default: ready = 1'($urandom % 2);
            endcase
            start = poke && (cyc == 10);
            if ((abort == 1 && cyc == 12) || (abort == 2 && m_valid)) begin
                if (abort == 1) chk({tag, "_abort_sel"}, 32'(m_sel), 32'd5);
                else chk({tag, "_abort_valid"}, 32'(m_valid), 32'd1);
                ready = 1'b0;
                rst   = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_reset(tag);
                return;
            end
            if (held_pend) chk({tag, "_hold"}, {27'd0, m_valid, m_term}, {27'd0, 1'b1, held});
            if (m_valid) begin
                if (ready) begin
                    got_q.push_back(m_term);
                    held_pend = 1'b0;
                end else begin
                    held_pend = 1'b1;
                    held      = m_term;
                end
            end else begin
                held_pend = 1'b0;
            end
            if (m_done || cyc >= 400) break;
            @(negedge clk);
            cyc++;
        end
        ready = 1'b0;
        start = 1'b0;

        chk({tag, "_done"},   32'(m_done),  32'd1);
        chk({tag, "_count"},  32'(m_count), 32'(exp_q.size()));
        chk({tag, "_table"},  32'(m_table), 32'(exp_tab));
        chk({tag, "_nterms"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, "_term"}, 32'(got_q[i]), 32'(exp_q[i]));
        end
        if (rmode == 0) chk({tag, "_cycles"}, 32'(cyc), 32'(3 * size + exp_q.size() + 1));

        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(m_done),  32'd0);
        chk({tag, "_idle_busy"},  32'(m_busy),  32'd0);
        chk({tag, "_idle_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_idle_sel"},   32'(m_sel),   32'(size - 1));
        chk({tag, "_hold_count"}, 32'(m_count), 32'(exp_q.size()));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        tt3   = '0;
        tt4   = '0;
        use3  = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset("init3");
        use3 = 1'b0;
        #1;
        check_reset("init4");
        @(negedge clk);
        rst = 1'b0;

        run(1'b1, 16'h0039, 0, 0, 1'b0, "n3_1267");
        run(1'b0, 16'h7C69, 1, 0, 1'b0, "n4_toggle");
        run(1'b0, 16'hFFFF, 0, 0, 1'b0, "n4_ones");
        run(1'b0, 16'h0000, 0, 0, 1'b0, "n4_zeros");
        run(1'b0, 16'hA5C3, 0, 1, 1'b0, "abort_sample");
        run(1'b0, 16'h7C69, 0, 2, 1'b0, "abort_emit");
        run(1'b0, 16'h7C69, 0, 0, 1'b0, "after_rst");
        run(1'b0, 16'h7C69, 0, 0, 1'b1, "poke");
        run(1'b0, 16'h7C69, 0, 0, 1'b0, "b2b");
        for (int r = 0; r < 6; r++) begin
            run(r % 2 == 0, 16'($urandom), 2, 0, 1'b0, "rand");
        end
        run(1'b1, 16'h0039, 0, 0, 1'b0, "n3_again");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
